// File: rtl/uart_tx_param_if.sv
// Word handshake between the producing logic and the UART transmitter.
// The producer drives din/valid; the transmitter answers with ready.
interface uart_tx_param_if #(
  parameter int DATA_BITS = 8
) ();
  logic [DATA_BITS-1:0] din;
  logic                 valid;
  logic                 ready;

  modport master (output din, output valid, input ready);
  modport slave  (input din, input valid, output ready);
endinterface

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: LSB-first frames with optional parity and
// one or two stop bits, gapless back-to-back when a word is offered at done.
module uart_tx_param #(
  parameter int CLKS_PER_BIT = 2604,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic            clk,
  input  logic            rst,
  uart_tx_param_if.slave  bus,
  output logic            tx,
  output logic            busy,
  output logic            done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_MAX       = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    IDX_DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    IDX_STOP_LAST = 4'(STOP_BITS - 1);
  localparam bit            HAS_PAR       = (PARITY == 1) || (PARITY == 2);
  localparam bit            ODD_PAR       = (PARITY == 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t               state, state_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic [3:0]           idx, idx_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic                 par_q, par_n;
  logic                 ready_q, ready_n;
  logic                 tx_n, busy_n, done_n;
  logic                 accept, wrap;

  assign bus.ready = ready_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      idx     <= '0;
      shreg   <= '0;
      par_q   <= 1'b0;
      ready_q <= 1'b0;
      tx      <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      idx     <= idx_n;
      shreg   <= shreg_n;
      par_q   <= par_n;
      ready_q <= ready_n;
      tx      <= tx_n;
      busy    <= busy_n;
      done    <= done_n;
    end
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    shreg_n = shreg;
    par_n   = par_q;
    accept  = bus.valid && ready_q;
    wrap    = (cnt == CNT_MAX);

    if (state != S_IDLE) cnt_n = wrap ? '0 : cnt + 1'b1;

    case (state)
      S_IDLE: begin
        if (accept) begin
          state_n = S_START;
          cnt_n   = '0;
          shreg_n = bus.din;
          par_n   = (^bus.din) ^ ODD_PAR;
        end
      end
      S_START: begin
        if (wrap) begin
          state_n = S_DATA;
          idx_n   = '0;
        end
      end
      S_DATA: begin
        if (wrap) begin
          shreg_n = shreg >> 1;
          if (idx == IDX_DATA_LAST) begin
            state_n = HAS_PAR ? S_PARITY : S_STOP;
            idx_n   = '0;
          end else begin
            idx_n = idx + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (wrap) begin
          state_n = S_STOP;
          idx_n   = '0;
        end
      end
      S_STOP: begin
        if (wrap) begin
          if (idx == IDX_STOP_LAST) begin
            idx_n = '0;
            // ready is high only in this cycle, so accept chains the next frame
            if (accept) begin
              state_n = S_START;
              cnt_n   = '0;
              shreg_n = bus.din;
              par_n   = (^bus.din) ^ ODD_PAR;
            end else begin
              state_n = S_IDLE;
            end
          end else begin
            idx_n = idx + 1'b1;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase

    // Outputs are decoded from the next state so the registered copies line
    // up with the bit being entered.
    done_n  = (state_n == S_STOP) && (idx_n == IDX_STOP_LAST) && (cnt_n == CNT_MAX);
    ready_n = (state_n == S_IDLE) || done_n;
    busy_n  = (state_n != S_IDLE);
    case (state_n)
      S_START:  tx_n = 1'b0;
      S_DATA:   tx_n = shreg_n[0];
      S_PARITY: tx_n = par_n;
      default:  tx_n = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: four configurations share clk/rst and are
// exercised one at a time against hand-computed frame bit patterns.
module tb_uart_tx_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [3:0] valid_v;
  logic [8:0] din_v [4];
  wire  [3:0] tx_v, busy_v, done_v, ready_v;

  int errors = 0;
  int checks = 0;

  uart_tx_param_if #(.DATA_BITS(8)) if0 ();
  uart_tx_param_if #(.DATA_BITS(8)) if1 ();
  uart_tx_param_if #(.DATA_BITS(8)) if2 ();
  uart_tx_param_if #(.DATA_BITS(7)) if3 ();

  assign if0.valid = valid_v[0];
  assign if1.valid = valid_v[1];
  assign if2.valid = valid_v[2];
  assign if3.valid = valid_v[3];
  assign if0.din   = din_v[0][7:0];
  assign if1.din   = din_v[1][7:0];
  assign if2.din   = din_v[2][7:0];
  assign if3.din   = din_v[3][6:0];
  assign ready_v[0] = if0.ready;
  assign ready_v[1] = if1.ready;
  assign ready_v[2] = if2.ready;
  assign ready_v[3] = if3.ready;

  uart_tx_param #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_dut0 (
    .clk(clk), .rst(rst), .bus(if0.slave), .tx(tx_v[0]), .busy(busy_v[0]), .done(done_v[0]));
  uart_tx_param #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_dut1 (
    .clk(clk), .rst(rst), .bus(if1.slave), .tx(tx_v[1]), .busy(busy_v[1]), .done(done_v[1]));
  uart_tx_param #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_dut2 (
    .clk(clk), .rst(rst), .bus(if2.slave), .tx(tx_v[2]), .busy(busy_v[2]), .done(done_v[2]));
  uart_tx_param #(.CLKS_PER_BIT(3), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u_dut3 (
    .clk(clk), .rst(rst), .bus(if3.slave), .tx(tx_v[3]), .busy(busy_v[3]), .done(done_v[3]));

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Waits (bounded) for ready, offers the word, returns #1 after the accept edge.
  task automatic start_frame(input int u, input logic [8:0] word, input bit hold);
    int n = 0;
    @(negedge clk);
    while (ready_v[u] !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("u%0d_ready_before_send", u), 32'(ready_v[u]), 32'd1);
    din_v[u]   = word;
    valid_v[u] = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) valid_v[u] = 1'b0;
  endtask

  // Checks every cycle after an accept edge; bits[k] is frame bit k.
  task automatic check_frame(input int u, input logic [15:0] bits, input int nbits,
                             input int cpb, input int limit, input bit disturb,
                             input string tag);
    int total = nbits * cpb;
    int k;
    for (int c = 1; c <= limit; c++) begin
      @(negedge clk);
      k = (c - 1) / cpb;
      check($sformatf("%s_c%0d_tx", tag, c),    32'(tx_v[u]),    32'(bits[k]));
      check($sformatf("%s_c%0d_busy", tag, c),  32'(busy_v[u]),  32'd1);
      check($sformatf("%s_c%0d_done", tag, c),  32'(done_v[u]),  32'(c == total));
      check($sformatf("%s_c%0d_ready", tag, c), 32'(ready_v[u]), 32'(c == total));
      if (disturb && c == 10) begin
        valid_v[u] = 1'b1;
        din_v[u]   = ~din_v[u];
      end
      if (disturb && c == 14) valid_v[u] = 1'b0;
    end
  endtask

  task automatic check_idle(input int u, input int n, input string tag);
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      check($sformatf("%s_c%0d_tx", tag, c),    32'(tx_v[u]),    32'd1);
      check($sformatf("%s_c%0d_busy", tag, c),  32'(busy_v[u]),  32'd0);
      check($sformatf("%s_c%0d_done", tag, c),  32'(done_v[u]),  32'd0);
      check($sformatf("%s_c%0d_ready", tag, c), 32'(ready_v[u]), 32'd1);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    rst     = 1'b1;
    valid_v = '0;
    for (int i = 0; i < 4; i++) din_v[i] = '0;

    // valid held high during reset must not be accepted
    valid_v[0] = 1'b1;
    din_v[0]   = 9'h0FF;
    repeat (3) @(negedge clk);
    for (int u = 0; u < 4; u++) begin
      check($sformatf("u%0d_rst_tx", u),    32'(tx_v[u]),    32'd1);
      check($sformatf("u%0d_rst_ready", u), 32'(ready_v[u]), 32'd0);
      check($sformatf("u%0d_rst_busy", u),  32'(busy_v[u]),  32'd0);
      check($sformatf("u%0d_rst_done", u),  32'(done_v[u]),  32'd0);
    end
    valid_v[0] = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    for (int u = 0; u < 4; u++) begin
      check($sformatf("u%0d_ready_after_rst", u), 32'(ready_v[u]), 32'd1);
      check($sformatf("u%0d_busy_after_rst", u),  32'(busy_v[u]),  32'd0);
    end

    // 8'hA5: 0,1,0,1,0,0,1,0,1,1
    start_frame(0, 9'h0A5, 1'b0);
    check_frame(0, 16'b11_0100_1010, 10, 4, 40, 1'b0, "basic");
    check_idle(0, 3, "basic_idle");

    // 8'h07 even parity -> parity bit 1; odd -> 0
    start_frame(1, 9'h007, 1'b0);
    check_frame(1, 16'b110_0000_1110, 11, 4, 44, 1'b0, "par_even");
    check_idle(1, 2, "par_even_idle");
    start_frame(2, 9'h007, 1'b0);
    check_frame(2, 16'b100_0000_1110, 11, 4, 44, 1'b0, "par_odd");
    check_idle(2, 2, "par_odd_idle");

    // 7'h41, two stop bits: 0,1,0,0,0,0,0,1,1,1
    start_frame(3, 9'h041, 1'b0);
    check_frame(3, 16'b11_1000_0010, 10, 3, 30, 1'b0, "w7s2");
    check_idle(3, 2, "w7s2_idle");

    // back-to-back 8'h55 then 8'hAA with valid held high throughout
    start_frame(0, 9'h055, 1'b1);
    din_v[0] = 9'h0AA;
    check_frame(0, 16'b10_1010_1010, 10, 4, 40, 1'b0, "b2b_first");
    @(posedge clk);
    #1;
    valid_v[0] = 1'b0;
    check_frame(0, 16'b11_0101_0100, 10, 4, 40, 1'b0, "b2b_second");
    check_idle(0, 3, "b2b_idle");

    // valid pulse and din change mid-frame are ignored and not queued
    start_frame(0, 9'h03C, 1'b0);
    check_frame(0, 16'b10_0111_1000, 10, 4, 40, 1'b1, "ignored");
    check_idle(0, 6, "no_queue");

    // reset during data bit 3 (frame bit 4, cycles 17..20)
    start_frame(0, 9'h0C3, 1'b0);
    check_frame(0, 16'b11_1000_0110, 10, 4, 18, 1'b0, "rst_mid");
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_tx",    32'(tx_v[0]),    32'd1);
    check("rst_mid_busy",  32'(busy_v[0]),  32'd0);
    check("rst_mid_ready", 32'(ready_v[0]), 32'd0);
    check("rst_mid_done",  32'(done_v[0]),  32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_ready_back", 32'(ready_v[0]), 32'd1);
    check("rst_mid_tx_idle",    32'(tx_v[0]),    32'd1);
    check("rst_mid_done_none",  32'(done_v[0]),  32'd0);
    start_frame(0, 9'h081, 1'b0);
    check_frame(0, 16'b11_0000_0010, 10, 4, 40, 1'b0, "after_rst");
    check_idle(0, 2, "after_rst_idle");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_param.md
# uart_tx_param

Parametrised UART transmitter, the next-generation serial TX for the FPGA debug/result link. It accepts one data word per valid/ready handshake and serialises it LSB-first with configurable data width, optional parity and one or two stop bits. Its bit timing comes from an internal baud counter. It sits between the result/counter logic that produces bytes and the board TX pin. Back-to-back words are sent with no idle gap.

## Interface
- CLKS_PER_BIT, default 2604: clock cycles per serial bit (25 MHz / 9600 baud); legal range ≥ 2.
- DATA_BITS, default 8: data bits per frame; legal range 5..9.
- PARITY, default 0: parity mode. 0 = none, 1 = odd, 2 = even.
- STOP_BITS, default 1: stop bits per frame; legal values 1 or 2.
- clk  in  1  single system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- din  in  DATA_BITS  word to send; sampled only on accept.
- valid  in  1  upstream has a word on din.
- ready  out  1  block can accept a word this cycle.
- tx  out  1  serial line, idle high.
- busy  out  1  a frame is in progress (start..last stop bit).
- done  out  1  one-cycle pulse in the final clock of the final stop bit.

## Operation
- Accept occurs on a rising edge where valid && ready. On accept, din is latched into a shift register; later changes to din do not affect the frame.
- Frame order: start (0), data bits LSB-first, parity bit if PARITY≠0, then STOP_BITS stop bits (1).
- FRAME_BITS = 1 + DATA_BITS + (PARITY≠0) + STOP_BITS.
- Parity:
  - even: XOR of the DATA_BITS latched bits.
  - odd: inverse of that XOR.
  - Computed from the latched word, never from live din.
- State machine: IDLE, START, DATA, PARITY, STOP.
  - IDLE→START on accept.
  - START→DATA after CLKS_PER_BIT cycles.
  - DATA→PARITY (or →STOP if PARITY=0) after DATA_BITS bit periods.
  - PARITY→STOP after one bit period.
  - STOP→IDLE after STOP_BITS bit periods, or STOP→START if accept occurs in its final cycle.
- Baud counter: runs 0..CLKS_PER_BIT-1, cleared on accept, wraps at CLKS_PER_BIT-1. The bit index advances on wrap.
- The counter width is derived from CLKS_PER_BIT (clog2). It must hold CLKS_PER_BIT-1 without overflow.
- ready is high in every IDLE cycle and in the final clock of the final stop bit; low otherwise.
- valid while ready is low is ignored. There is no buffering beyond the one frame in flight.
- PARITY values other than 0..2 behave as 0.

## Timing
- Reset values: tx=1, ready=0, busy=0, done=0; state IDLE, counters 0, shift register 0.
- ready rises in the first cycle after rst deasserts.
- All outputs are registered.
- Accept at edge T: tx=0 from T+1 for exactly CLKS_PER_BIT cycles.
- Bit k of the frame (k=0 start) is driven during cycles T+1+k·CLKS_PER_BIT .. T+(k+1)·CLKS_PER_BIT.
- busy is high over the same span as the frame bits: T+1 .. T+FRAME_BITS·CLKS_PER_BIT.
- done and ready are both high in cycle T+FRAME_BITS·CLKS_PER_BIT.
- Gapless back-to-back: accept in the done cycle means the next start bit begins the following cycle. tx never glitches high between frames except during the stop bits. busy stays high.
- Reset mid-frame: at the rst edge the frame is abandoned and tx=1 at the next cycle. No done pulse is produced; the partial frame is not resumed.
- rst and valid high together: reset wins and the word is not accepted.
- Per-frame latency from accept to done: FRAME_BITS·CLKS_PER_BIT cycles (10·2604 = 26040 at the defaults).

## Test plan
- Basic frame. Config: defaults except CLKS_PER_BIT=4. Stimulus: send 8'hA5. Required response:
  - tx = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles.
  - done is high exactly at cycle 40 after accept.
  - ready is low between accept and done.
- Parity. Config: CLKS_PER_BIT=4, PARITY=2. Stimulus: send 8'h07. Required response: parity bit = 1. With PARITY=1 it is 0. The frame is 11 bits (44 cycles).
- Width and stop bits. Config: CLKS_PER_BIT=3, DATA_BITS=7, STOP_BITS=2. Stimulus: send 7'h41. Required response:
  - bits are 0,1,0,0,0,0,0,1,1,1.
  - done is high at cycle 30.
- Back-to-back. Config: CLKS_PER_BIT=4. Stimulus: hold valid high with 8'h55 then 8'hAA. Required response:
  - the second start bit begins at cycle 41.
  - there is no extra idle cycle.
  - busy never drops between the frames.
  - exactly two done pulses.
- Ignored input. Stimulus: pulse valid mid-frame, and change din mid-frame. Required response: the frame is unchanged and nothing is queued.
- Reset mid-frame. Stimulus: assert rst during data bit 3. Required response:
  - the next cycle has tx=1, busy=0, ready=0, with no done pulse.
  - one cycle after rst drops, ready=1 and a new frame sends correctly.
